// File: rtl/mips_mc_controller_hs_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller and its datapath:
// FSM states, opcode/funct constants, ALU control and mux select encodings.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_ERROR
  } state_t;

  // Opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (inst[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REGA   = 2'b11;

  // Destination register select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  // Writeback source select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that talk to memory and are therefore subject to the wait limit
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_controller_hs_alu_decode.sv
// Combinational ALU-control decode: maps opcode/funct to the ALU operation
// and flags R-type funct codes the controller does not implement.
module mips_alu_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  // Decode the ALU operation; anything not an R-type or slti uses add
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          FN_JR:   o_alu_ctrl = ALU_ADD;
          default: o_illegal  = 1'b1;
        endcase
      end
      OP_SLTI: o_alu_ctrl = ALU_SLT;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller_hs.sv
// Multi-cycle MIPS32 control unit with memory-ready handshake, bounded wait
// states and a sticky ERROR state. Optional performance counters are enabled
// by defining MIPS_MC_PERF_EN.
module mips_mc_controller_hs
  import mips_mc_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        lord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_src_b,
  output logic        error
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [2:0]        w_alu_ctrl;
  logic              w_illegal_funct;
  logic              w_wait_at_limit;
  logic              w_unused;

  assign w_opcode        = inst[31:26];
  assign w_funct         = inst[5:0];
  assign w_wait_at_limit = (r_wait_cnt == L_MAX_WAIT);
  assign w_unused        = ^inst[25:6];

  mips_alu_decode u_alu_decode (
    .i_opcode   (w_opcode),
    .i_funct    (w_funct),
    .o_alu_ctrl (w_alu_ctrl),
    .o_illegal  (w_illegal_funct)
  );

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next_state;
  end

  // Wait counter: counts stalled cycles within one memory access, cleared on
  // completion and whenever a memory state is entered or left
  always_ff @(posedge clk) begin
    if (!rst)
      r_wait_cnt <= '0;
    else if (is_mem_state(r_state) && !mem_ready && (w_next_state == r_state))
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end

  // Next-state and control outputs; everything is held at 0 during reset
  always_comb begin
    w_next_state = r_state;
    pc_en        = 1'b0;
    lord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = M2R_ALUOUT;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_ctrl     = ALU_AND;
    pc_src       = PC_SRC_ALU;
    reg_dst      = REG_DST_RT;
    alu_src_b    = ALU_B_REG;
    error        = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_B_FOUR;
          alu_ctrl  = ALU_ADD;
          // completion beats the timeout when both happen together
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_en        = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_wait_at_limit) begin
            w_next_state = S_ERROR;
          end
        end
        S_DECODE: begin
          alu_src_b = ALU_B_IMM_SH;
          alu_ctrl  = ALU_ADD;
          case (w_opcode)
            OP_RTYPE: begin
              if (w_funct == FN_JR)      w_next_state = S_JR;
              else if (w_illegal_funct)  w_next_state = S_ERROR;
              else                       w_next_state = S_R_EXEC;
            end
            OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE:   w_next_state = S_BRANCH;
            OP_ADDI, OP_SLTI: w_next_state = S_I_EXEC;
            OP_J:             w_next_state = S_JUMP;
            OP_JAL:           w_next_state = S_JAL;
            default:          w_next_state = S_ERROR;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = ALU_B_IMM;
          alu_ctrl     = ALU_ADD;
          w_next_state = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          lord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready)            w_next_state = S_MEM_WB;
          else if (w_wait_at_limit) w_next_state = S_ERROR;
        end
        S_MEM_WB: begin
          reg_dst      = REG_DST_RT;
          mem_to_reg   = M2R_MDR;
          reg_write    = 1'b1;
          w_next_state = S_FETCH;
        end
        S_MEM_WR: begin
          lord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready)            w_next_state = S_FETCH;
          else if (w_wait_at_limit) w_next_state = S_ERROR;
        end
        S_R_EXEC: begin
          alu_src_a    = 1'b1;
          alu_src_b    = ALU_B_REG;
          alu_ctrl     = w_alu_ctrl;
          w_next_state = S_R_WB;
        end
        S_R_WB: begin
          reg_dst      = REG_DST_RD;
          mem_to_reg   = M2R_ALUOUT;
          reg_write    = 1'b1;
          w_next_state = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a    = 1'b1;
          alu_src_b    = ALU_B_IMM;
          alu_ctrl     = w_alu_ctrl;
          w_next_state = S_I_WB;
        end
        S_I_WB: begin
          reg_dst      = REG_DST_RT;
          mem_to_reg   = M2R_ALUOUT;
          reg_write    = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a    = 1'b1;
          alu_src_b    = ALU_B_REG;
          alu_ctrl     = ALU_SUB;
          pc_src       = PC_SRC_ALUOUT;
          pc_en        = (w_opcode == OP_BNE) ? !zero : zero;
          w_next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_src       = PC_SRC_JUMP;
          pc_en        = 1'b1;
          w_next_state = S_FETCH;
        end
        S_JAL: begin
          // PC already points past the jal, so it is the link value
          reg_dst      = REG_DST_RA;
          mem_to_reg   = M2R_PC;
          reg_write    = 1'b1;
          pc_src       = PC_SRC_JUMP;
          pc_en        = 1'b1;
          w_next_state = S_FETCH;
        end
        S_JR: begin
          pc_src       = PC_SRC_REGA;
          pc_en        = 1'b1;
          w_next_state = S_FETCH;
        end
        S_ERROR: begin
          error = 1'b1;
        end
        default: w_next_state = S_ERROR;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  // Cycle counter: all running cycles outside reset and ERROR
  always_ff @(posedge clk) begin
    if (!rst)                    cycle_cnt <= '0;
    else if (r_state != S_ERROR) cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Retired-instruction counter: every return to FETCH ends an instruction
  always_ff @(posedge clk) begin
    if (!rst)
      instr_cnt <= '0;
    else if ((r_state != S_FETCH) && (w_next_state == S_FETCH))
      instr_cnt <= instr_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/mips_mc_controller_hs.md
Name: mips_mc_controller_hs

Overview:
Next-generation multi-cycle MIPS32 control unit that drives the existing multi-cycle datapath. Differences from the current controller:
- Memory ready handshake with wait states, bounded by a timeout.
- Wider instruction set: bne, slti, jal, jr.
- 2-bit writeback select.
- Sticky error state for illegal opcodes and memory timeouts.

It sits beside the datapath inside the core top and reads `inst` (IR output) and `zero`.

Parameters:
- MAX_WAIT, 16, memory wait cycles tolerated per access before entering ERROR (1..255).
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- inst  in  32  instruction from IR; opcode = [31:26], funct = [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC write enable (unconditional OR qualified branch).
- lord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC (jal).
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_ctrl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- error  out  1  sticky error flag.

Behaviour:
- Reset:
  - rst = 0 sampled at a clk edge: state <= FETCH, wait counter <= 0, error <= 0.
  - While rst = 0, all outputs are forced to 0 combinationally.
  - Reset mid-access abandons the access; no write-enable is asserted on the reset cycle.
- Default: every output not listed for a state is 0.
- FETCH:
  - mem_read = 1, lord = 0, alu_src_a = 0, alu_src_b = 01, alu_ctrl = add, pc_src = 00.
  - ir_write and pc_en are asserted only in the cycle where mem_ready = 1; the FSM then goes to DECODE.
  - Otherwise the FSM stays in FETCH and increments the wait counter.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_ctrl = add (branch target into ALUOut). Next state by opcode:
  - 000000 (R-type): funct 001000 -> JR; add/sub/and/or/slt -> R_EXEC; other funct -> ERROR.
  - 100011 lw / 101011 sw -> MEM_ADDR.
  - 000100 beq / 000101 bne -> BRANCH.
  - 001000 addi / 001010 slti -> I_EXEC.
  - 000010 j -> JUMP.
  - 000011 jal -> JAL.
  - Any other opcode -> ERROR.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, add. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: lord = 1, mem_read = 1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_dst = 00, mem_to_reg = 01, reg_write = 1. Next state FETCH.
- MEM_WR: lord = 1, mem_write = 1. Wait for mem_ready, then FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_ctrl from funct. Next state R_WB.
- R_WB: reg_dst = 01, mem_to_reg = 00, reg_write = 1. Next state FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_ctrl = add (addi) or slt (slti). Next state I_WB.
- I_WB: reg_dst = 00, mem_to_reg = 00, reg_write = 1. Next state FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01.
  - pc_en = zero for beq; pc_en = !zero for bne.
  - Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.
- JAL: reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_src = 10, pc_en = 1. Next state FETCH.
  - The register file is written with the already-incremented PC.
- JR: pc_src = 11, pc_en = 1. Next state FETCH.
- Wait counter (memory states FETCH, MEM_RD, MEM_WR only):
  - Cleared on entry to each memory state and whenever mem_ready = 1.
  - When the counter equals MAX_WAIT and mem_ready = 0 -> ERROR.
  - mem_ready = 1 on the same cycle as the limit: completion wins.
- ERROR: all outputs 0 except error = 1. Exit only via reset.
- Latency with mem_ready tied high:
  - R-type, addi, slti, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Each memory wait cycle adds 1.

Optional Feature:
- MIPS_MC_PERF_EN defined:
  - Extra outputs cycle_cnt[31:0] and instr_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every non-reset, non-ERROR cycle.
  - instr_cnt increments on each transition into FETCH from a completing state.
  - Both wrap modulo 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_mc_pkg holds:
  - state_t enum.
  - Opcode and funct constants.
  - alu_ctrl constants.
  - pc_src, reg_dst, alu_src_b and mem_to_reg encodings.
  - These are shared with the datapath.
- One sub-module, mips_alu_decode: combinational funct/opcode -> alu_ctrl plus illegal flag.

Test Plan:
- mem_ready = 1, inst = add $3,$1,$2 (0x00221820) -> cycle 1 ir_write = 1 and pc_en = 1; cycle 4 reg_write = 1, reg_dst = 01, mem_to_reg = 00; back in FETCH at cycle 5.
- lw (0x8C220004) with mem_ready low for 3 cycles in MEM_RD -> mem_read held with lord = 1 for 4 cycles; MEM_WB with mem_to_reg = 01 follows; total 8 cycles.
- beq with zero = 1 -> pc_en = 1, pc_src = 01. bne with zero = 1 -> pc_en = 0.
- jal (0x0C000010) -> reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_en = 1, pc_src = 10 in cycle 3.
- mem_ready = 0 in FETCH for MAX_WAIT + 1 cycles -> error = 1, all other outputs 0. Illegal opcode 0x3F -> ERROR after DECODE. rst = 0 for one edge -> FETCH, error = 0.
- rst asserted during MEM_WR -> next cycle mem_write = 0; after release FETCH resumes with mem_read = 1.
